ch3_wave_sequencer: RTL and testbench

//  Channel-3 playback sequencer, upstream of the wave RAM stage. Runs the 11-bit

---
 rtl/ch3_wave_sequencer.sv | 149 ++++++++++++++
 tb/tb_ch3_wave_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ch3_wave_sequencer.sv
// Channel-3 playback sequencer: frequency timer, sample index, trigger/DAC control and
// volume-shifted output. Defining CH3_LENGTH_EN adds the 256 Hz length counter.
module ch3_wave_sequencer #(
  parameter int FREQ_W = 11,
  parameter int POS_W  = 5,
  parameter int LEN_W  = 9
) (
  input  logic              amuk_4mhz,
  input  logic              napu_reset,
  input  logic              tick_2mhz,
  input  logic              tick_256hz,
  input  logic              dac_on,
  input  logic              trigger,
  input  logic [FREQ_W-1:0] freq,
  input  logic              length_load,
  input  logic [7:0]        nr31,
  input  logic              length_en,
  input  logic [1:0]        vol_code,
  input  logic [3:0]        wave_play_d,
  output logic [POS_W-2:0]  wave_addr,
  output logic              efar_q,
  output logic              sample_fetch,
  output logic              ch3_active,
  output logic [3:0]        ch3_out
);

  localparam logic [FREQ_W-1:0] TIMER_MAX = {FREQ_W{1'b1}};

  logic [FREQ_W-1:0] timer_q, timer_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              active_q, active_d;
  logic              fetch_q, fetch_d;
  logic [3:0]        out_q, out_d;
  logic              trig_s;
  logic              run_s;
  logic              len_expire_s;

  // NR32 volume: mute, full, half, quarter with zero fill from the top.
  function automatic logic [3:0] vol_shift(input logic [1:0] code, input logic [3:0] d);
    logic [3:0] r;
    case (code)
      2'd0:    r = 4'd0;
      2'd1:    r = d;
      2'd2:    r = {1'b0, d[3:1]};
      2'd3:    r = {2'b00, d[3:2]};
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  assign trig_s = trigger & dac_on;
  assign run_s  = active_q & dac_on & tick_2mhz;

`ifdef CH3_LENGTH_EN
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(256);

  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_load_s;
  logic [LEN_W-1:0] len_base_s;

  assign len_load_s = LEN_FULL - LEN_W'(nr31);
  assign len_base_s = length_load ? len_load_s : len_q;

  // Length counter: a same-cycle load lands before the trigger looks at it,
  // and a trigger swallows a coincident 256 Hz decrement.
  always_comb begin
    len_d        = len_q;
    len_expire_s = 1'b0;
    if (trig_s) begin
      len_d = (len_base_s == {LEN_W{1'b0}}) ? LEN_FULL : len_base_s;
    end else if (length_load) begin
      len_d = len_load_s;
    end else if (tick_256hz && length_en && (len_q != {LEN_W{1'b0}})) begin
      len_d        = len_q - LEN_W'(1);
      len_expire_s = (len_q == LEN_W'(1));
    end else begin
      len_d = len_q;
    end
  end

  // Length state register.
  always_ff @(posedge amuk_4mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      len_q <= {LEN_W{1'b0}};
    end else begin
      len_q <= len_d;
    end
  end
`else
  logic unused_len_s;
  assign unused_len_s = ^{length_load, nr31, length_en, tick_256hz};
  assign len_expire_s = 1'b0;
`endif

  // Timer, sample index and enable: trigger outranks every other event.
  always_comb begin
    timer_d  = timer_q;
    pos_d    = pos_q;
    fetch_d  = 1'b0;
    active_d = active_q;
    if (trig_s) begin
      timer_d  = freq;
      pos_d    = {POS_W{1'b0}};
      active_d = 1'b1;
    end else begin
      if (run_s) begin
        if (timer_q == TIMER_MAX) begin
          timer_d = freq;
          pos_d   = pos_q + POS_W'(1);
          fetch_d = 1'b1;
        end else begin
          timer_d = timer_q + FREQ_W'(1);
        end
      end else begin
        timer_d = timer_q;
      end
      if (!dac_on || len_expire_s) begin
        active_d = 1'b0;
      end else begin
        active_d = active_q;
      end
    end
    out_d = active_q ? vol_shift(vol_code, wave_play_d) : 4'd0;
  end

  // Core state and registered outputs.
  always_ff @(posedge amuk_4mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      timer_q  <= {FREQ_W{1'b0}};
      pos_q    <= {POS_W{1'b0}};
      active_q <= 1'b0;
      fetch_q  <= 1'b0;
      out_q    <= 4'd0;
    end else begin
      timer_q  <= timer_d;
      pos_q    <= pos_d;
      active_q <= active_d;
      fetch_q  <= fetch_d;
      out_q    <= out_d;
    end
  end

  assign wave_addr    = pos_q[POS_W-1:1];
  assign efar_q       = pos_q[0];
  assign sample_fetch = fetch_q;
  assign ch3_active   = active_q;
  assign ch3_out      = out_q;

endmodule

// File: tb/tb_ch3_wave_sequencer.sv
// Scoreboard bench for ch3_wave_sequencer: a period/countdown reference model pushes
// expected per-cycle state and fetch addresses; a monitor pops and compares them.
module tb_ch3_wave_sequencer;

  logic        clk = 1'b0;
  logic        napu_reset;
  logic        tick_2mhz, tick_256hz, dac_on, trigger, length_load, length_en;
  logic [10:0] freq;
  logic [7:0]  nr31;
  logic [1:0]  vol_code;
  logic [3:0]  wave_play_d;
  logic [3:0]  wave_addr;
  logic        efar_q, sample_fetch, ch3_active;
  logic [3:0]  ch3_out;

  ch3_wave_sequencer dut (
    .amuk_4mhz(clk), .napu_reset(napu_reset), .tick_2mhz(tick_2mhz),
    .tick_256hz(tick_256hz), .dac_on(dac_on), .trigger(trigger), .freq(freq),
    .length_load(length_load), .nr31(nr31), .length_en(length_en),
    .vol_code(vol_code), .wave_play_d(wave_play_d), .wave_addr(wave_addr),
    .efar_q(efar_q), .sample_fetch(sample_fetch), .ch3_active(ch3_active),
    .ch3_out(ch3_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;
    int active;
    int fetch;
    int out;
  } snap_t;

  snap_t exp_q[$];
  int    fetch_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  int m_pos, m_rem, m_len, m_active;
  bit rnd_d = 1'b1;
  logic [3:0] d_fix = 4'hF;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_rem = 2048; m_len = 0; m_active = 0;
  endtask

  // Reference: one playback step from the programmer-visible rules.
  task automatic model_step();
    snap_t s;
    int    new_active;
    s.out = (m_active != 0 && vol_code != 2'd0) ?
            (int'(wave_play_d) >> (int'(vol_code) - 1)) : 0;
    s.fetch    = 0;
    new_active = m_active;
    if (trigger && dac_on) begin
      m_pos = 0;
      m_rem = 2048 - int'(freq);
      new_active = 1;
`ifdef CH3_LENGTH_EN
      if (length_load) m_len = 256 - int'(nr31);
      if (m_len == 0) m_len = 256;
`endif
    end else begin
      if (m_active != 0 && dac_on && tick_2mhz) begin
        m_rem--;
        if (m_rem == 0) begin
          m_pos   = (m_pos + 1) % 32;
          m_rem   = 2048 - int'(freq);
          s.fetch = 1;
          fetch_q.push_back(m_pos);
        end
      end
`ifdef CH3_LENGTH_EN
      if (length_load) m_len = 256 - int'(nr31);
      else if (tick_256hz && length_en && m_len > 0) begin
        m_len--;
        if (m_len == 0) new_active = 0;
      end
`endif
      if (!dac_on) new_active = 0;
    end
    m_active = new_active;
    s.pos    = m_pos;
    s.active = m_active;
    exp_q.push_back(s);
  endtask

  task automatic cyc(input bit trg, input bit t2, input bit t256, input bit ll);
    @(negedge clk);
    trigger = trg; tick_2mhz = t2; tick_256hz = t256; length_load = ll;
    wave_play_d = rnd_d ? 4'($urandom) : d_fix;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid();
    #2;
    trigger = 1'b0; tick_2mhz = 1'b0; tick_256hz = 1'b0; length_load = 1'b0;
    napu_reset = 1'b0;
    #1;
    chk("rst_out", int'(ch3_out), 0);
    chk("rst_active", int'(ch3_active), 0);
    chk("rst_fetch", int'(sample_fetch), 0);
    chk("rst_pos", int'({wave_addr, efar_q}), 0);
    model_reset();
    @(negedge clk);
    napu_reset = 1'b1;
  endtask

  // Monitor: every presented cycle is compared, every fetch pulse consumes an address.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pos", int'({wave_addr, efar_q}), e.pos);
        chk("active", int'(ch3_active), e.active);
        chk("fetch", int'(sample_fetch), e.fetch);
        chk("ch3_out", int'(ch3_out), e.out);
      end
      if (sample_fetch === 1'b1) begin
        if (fetch_q.size() == 0) chk("fetch_unexpected", 1, 0);
        else chk("fetch_addr", int'({wave_addr, efar_q}), fetch_q.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    napu_reset = 1'b0; trigger = 1'b0; tick_2mhz = 1'b0; tick_256hz = 1'b0;
    dac_on = 1'b0; length_load = 1'b0; length_en = 1'b0; freq = 11'd0;
    nr31 = 8'd0; vol_code = 2'd1; wave_play_d = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_out", int'(ch3_out), 0);
    chk("reset_active", int'(ch3_active), 0);
    chk("reset_pos", int'({wave_addr, efar_q}), 0);
    napu_reset = 1'b1;

    // Fastest rate: one advance per tick, including the 31 -> 0 wrap.
    dac_on = 1'b1; freq = 11'd2047;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0);
    // Every second tick, then the slowest rate.
    freq = 11'd2046;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0);
    freq = 11'd0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4100; i++) cyc(0, 1, 0, 0);

    // Volume shifts on a full-scale sample, then muted by inactivity.
    rnd_d = 1'b0; freq = 11'd2047;
    cyc(1, 0, 0, 0);
    for (int v = 0; v < 4; v++) begin
      vol_code = 2'(v);
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    end
    dac_on = 1'b0;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    rnd_d = 1'b1; vol_code = 2'd1;

    // Trigger with DAC off stays idle; DAC off mid-play freezes pos.
    cyc(1, 1, 0, 0); cyc(0, 1, 0, 0);
    dac_on = 1'b1;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    dac_on = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    dac_on = 1'b1;
    cyc(0, 1, 0, 0);

    // Trigger coincident with overflow, length tick and length load.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    length_en = 1'b1; nr31 = 8'd250;
    cyc(1, 1, 1, 1);
    cyc(0, 1, 0, 0);

`ifdef CH3_LENGTH_EN
    // nr31=254 expires after exactly two 256 Hz ticks; len=0 gives 256 ticks.
    reset_mid();
    nr31 = 8'd254; length_en = 1'b1;
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); end
    reset_mid();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 257; i++) cyc(0, 0, 1, 0);
`endif

    // Reset in the middle of playback.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0);
    reset_mid();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) dac_on = ~dac_on;
      else if (!dac_on && $urandom_range(9) == 0) dac_on = 1'b1;
      if ($urandom_range(49) == 0) freq = 11'(2040 + $urandom_range(7));
      if ($urandom_range(29) == 0) vol_code = 2'($urandom);
      if ($urandom_range(99) == 0) length_en = ~length_en;
      nr31 = 8'($urandom_range(200, 255));
      cyc($urandom_range(59) == 0, $urandom_range(1) == 1,
          $urandom_range(19) == 0, $urandom_range(79) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("fetch_queue_drained", fetch_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
